ysyx_22040127_mem_arbiter: RTL

//  Shares one downstream memory port between IF (instruction fetch, read-only) and MEM-stage LSU
//  (load/store). Only one transaction is outstanding at a time. LSU has fixed priority, bounded by
//  a starvation counter. Fetch responses are squashed on pipeline flush (branch taken / mret).

---
 rtl/ysyx_22040127_mem_arbiter_if.sv | 57 +++++
 rtl/ysyx_22040127_mem_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/ysyx_22040127_mem_arbiter_if.sv
// Bus bundle for the IF/LSU memory arbiter: both requester ports, the downstream
// memory port and the busy flag. The slave view belongs to the arbiter; the
// master view belongs to whatever surrounds it (requesters plus memory).
interface ysyx_22040127_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    // Instruction fetch port (read-only)
    logic                  if_req_valid;
    logic [ADDR_W-1:0]     if_req_addr;
    logic                  if_req_ready;
    logic                  if_rsp_valid;
    logic [DATA_W-1:0]     if_rsp_rdata;
    logic                  if_flush;

    // Load/store port
    logic                  ls_req_valid;
    logic [ADDR_W-1:0]     ls_req_addr;
    logic                  ls_req_wen;
    logic [DATA_W-1:0]     ls_req_wdata;
    logic [DATA_W/8-1:0]   ls_req_wmask;
    logic                  ls_req_ready;
    logic                  ls_rsp_valid;
    logic [DATA_W-1:0]     ls_rsp_rdata;

    // Downstream memory port
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_W-1:0]     mem_req_addr;
    logic                  mem_req_wen;
    logic [DATA_W-1:0]     mem_req_wdata;
    logic [DATA_W/8-1:0]   mem_req_wmask;
    logic                  mem_rsp_valid;
    logic [DATA_W-1:0]     mem_rsp_rdata;

    logic                  busy;

    modport slave (
        input  if_req_valid, if_req_addr, if_flush,
        input  ls_req_valid, ls_req_addr, ls_req_wen, ls_req_wdata, ls_req_wmask,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
        output if_req_ready, if_rsp_valid, if_rsp_rdata,
        output ls_req_ready, ls_rsp_valid, ls_rsp_rdata,
        output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
        output busy
    );

    modport master (
        output if_req_valid, if_req_addr, if_flush,
        output ls_req_valid, ls_req_addr, ls_req_wen, ls_req_wdata, ls_req_wmask,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
        input  if_req_ready, if_rsp_valid, if_rsp_rdata,
        input  ls_req_ready, ls_rsp_valid, ls_rsp_rdata,
        input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
        input  busy
    );
endinterface

// File: rtl/ysyx_22040127_mem_arbiter.sv
// Shares one downstream memory port between instruction fetch and the LSU.
// One transaction in flight at a time; LSU has priority, limited by a streak
// counter so a continuously requesting LSU cannot starve fetch. Fetch responses
// are squashed when the pipeline flushes.
module ysyx_22040127_mem_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 64,
    parameter int MAX_LSU_STREAK = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    ysyx_22040127_mem_arbiter_if.slave        bus
);
    localparam int MASK_W   = DATA_W / 8;
    localparam int STREAK_W = $clog2(MAX_LSU_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_LSU_STREAK);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

    state_t              r_state,  w_state_nxt;
    owner_t              r_owner,  w_owner_nxt;
    logic                r_drop,   w_drop_nxt;
    logic [STREAK_W-1:0] r_streak, w_streak_nxt;
    logic [ADDR_W-1:0]   r_addr,   w_addr_nxt;
    logic                r_wen,    w_wen_nxt;
    logic [DATA_W-1:0]   r_wdata,  w_wdata_nxt;
    logic [MASK_W-1:0]   r_wmask,  w_wmask_nxt;

    logic w_if_ok;
    logic w_grant_if;
    logic w_grant_ls;
    logic w_rsp_done;
    logic w_if_rsp;
    logic w_ls_rsp;

    // Winner selection in IDLE: LSU first unless fetch has waited out a full streak.
    always_comb begin
        w_if_ok    = bus.if_req_valid && !bus.if_flush;
        w_grant_ls = 1'b0;
        w_grant_if = 1'b0;
        if (r_state == S_IDLE) begin
            if (bus.ls_req_valid && !(w_if_ok && (r_streak == STREAK_MAX))) begin
                w_grant_ls = 1'b1;
            end else if (w_if_ok) begin
                w_grant_if = 1'b1;
            end
        end
    end

    // Next-state, request latch, drop flag and streak bookkeeping.
    always_comb begin
        w_state_nxt  = r_state;
        w_owner_nxt  = r_owner;
        w_drop_nxt   = r_drop;
        w_streak_nxt = r_streak;
        w_addr_nxt   = r_addr;
        w_wen_nxt    = r_wen;
        w_wdata_nxt  = r_wdata;
        w_wmask_nxt  = r_wmask;
        case (r_state)
            S_IDLE: begin
                w_drop_nxt = 1'b0;
                if (w_grant_ls) begin
                    w_state_nxt = S_REQ;
                    w_owner_nxt = OWN_LS;
                    w_addr_nxt  = bus.ls_req_addr;
                    w_wen_nxt   = bus.ls_req_wen;
                    w_wdata_nxt = bus.ls_req_wdata;
                    w_wmask_nxt = bus.ls_req_wmask;
                    if (bus.if_req_valid && (r_streak != STREAK_MAX)) begin
                        w_streak_nxt = r_streak + STREAK_W'(1);
                    end
                end else if (w_grant_if) begin
                    w_state_nxt  = S_REQ;
                    w_owner_nxt  = OWN_IF;
                    w_addr_nxt   = bus.if_req_addr;
                    w_wen_nxt    = 1'b0;
                    w_wdata_nxt  = '0;
                    w_wmask_nxt  = '0;
                    w_streak_nxt = '0;
                end
            end
            S_REQ: begin
                if ((r_owner == OWN_IF) && bus.if_flush) begin
                    w_drop_nxt = 1'b1;
                end
                if (bus.mem_req_ready) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.mem_rsp_valid) begin
                    w_state_nxt = S_IDLE;
                    w_drop_nxt  = 1'b0;
                end else if ((r_owner == OWN_IF) && bus.if_flush) begin
                    w_drop_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and latched-request registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_owner  <= OWN_IF;
            r_drop   <= 1'b0;
            r_streak <= '0;
            r_addr   <= '0;
            r_wen    <= 1'b0;
            r_wdata  <= '0;
            r_wmask  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_owner  <= w_owner_nxt;
            r_drop   <= w_drop_nxt;
            r_streak <= w_streak_nxt;
            r_addr   <= w_addr_nxt;
            r_wen    <= w_wen_nxt;
            r_wdata  <= w_wdata_nxt;
            r_wmask  <= w_wmask_nxt;
        end
    end

    // Handshake outputs; held low during reset so no acceptance or response
    // is signalled for a transaction the reset is about to discard.
    always_comb begin
        w_rsp_done = (r_state == S_WAIT) && bus.mem_rsp_valid;
        w_if_rsp   = !rst && w_rsp_done && (r_owner == OWN_IF) && !r_drop && !bus.if_flush;
        w_ls_rsp   = !rst && w_rsp_done && (r_owner == OWN_LS);

        bus.if_req_ready  = !rst && w_grant_if;
        bus.ls_req_ready  = !rst && w_grant_ls;
        bus.if_rsp_valid  = w_if_rsp;
        bus.if_rsp_rdata  = w_if_rsp ? bus.mem_rsp_rdata : '0;
        bus.ls_rsp_valid  = w_ls_rsp;
        bus.ls_rsp_rdata  = (w_ls_rsp && !r_wen) ? bus.mem_rsp_rdata : '0;

        bus.mem_req_valid = !rst && (r_state == S_REQ);
        bus.mem_req_addr  = r_addr;
        bus.mem_req_wen   = r_wen;
        bus.mem_req_wdata = r_wdata;
        bus.mem_req_wmask = r_wmask;

        bus.busy          = (r_state != S_IDLE);
    end
endmodule
